// File: rtl/vpe_out_packer.sv
// -----------------------------------------------------------------------------
// vpe_out_packer
//   Collects signed O_WIDTH elements from the dequant stage, one per cycle, and
//   packs LANES of them into one unified-buffer write word. It also generates
//   the word address, the per-lane byte strobes and the burst-last flag. When
//   the write port stalls, it backpressures the upstream stage.
//
//   Storage: one assembly register and one output register. A completed word
//   can wait in the assembly register (pend) while the output register is
//   still held by the write port.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous, active-low reset
//   start          pulse that begins a burst and latches base_addr (ignored while busy)
//   base_addr      word address of the first output word of the burst
//   pack_in_valid  incoming element is valid
//   pack_in        incoming element
//   pack_in_last   the incoming element is the final element of the burst
//   pack_in_ready  the element is accepted when valid & ready
//   out_valid      the output word is valid
//   out_ready      the write port accepts the word when valid & ready
//   out_data       packed word; lane k is in bits [k*O_WIDTH +: O_WIDTH]
//   out_strb       per-lane write enable
//   out_addr       word address
//   out_last       the word holds the burst's last element
//   busy           a burst is in progress
// -----------------------------------------------------------------------------
module vpe_out_packer #(
    parameter int O_WIDTH    = 8,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic                       pack_in_valid,
    input  logic [O_WIDTH-1:0]         pack_in,
    input  logic                       pack_in_last,
    output logic                       pack_in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*O_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]           out_strb,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic                       out_last,
    output logic                       busy
);
    localparam int W  = LANES * O_WIDTH;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                  busy_reg;
    logic [LW-1:0]         lane_reg;
    logic [W-1:0]          asm_data_reg;
    logic [LANES-1:0]      asm_strb_reg;
    logic                  asm_last_reg;
    logic                  pend_reg;
    logic                  last_seen_reg;
    logic [ADDR_WIDTH-1:0] next_addr_reg;
    logic                  out_valid_reg;
    logic [W-1:0]          out_data_reg;
    logic [LANES-1:0]      out_strb_reg;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic                  out_last_reg;

    logic                  accept;
    logic                  drain;
    logic                  out_free;
    logic                  complete;
    logic                  load;
    logic [W-1:0]          word_data;
    logic [LANES-1:0]      word_strb;
    logic                  word_last;
    logic [W-1:0]          ld_data;
    logic [LANES-1:0]      ld_strb;
    logic                  ld_last;

    assign pack_in_ready = busy_reg & ~pend_reg & ~last_seen_reg;
    assign accept        = pack_in_valid & pack_in_ready;
    assign drain         = out_valid_reg & out_ready;
    // The output register can take a new word if it is empty or emptying this edge.
    assign out_free      = ~out_valid_reg | drain;
    assign complete      = accept & ((lane_reg == LW'(LANES - 1)) | pack_in_last);

    // Assembly word with the incoming element merged into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic hit;
            assign hit = accept & (lane_reg == LW'(gi));
            assign word_data[gi*O_WIDTH +: O_WIDTH] =
                hit ? pack_in : asm_data_reg[gi*O_WIDTH +: O_WIDTH];
            assign word_strb[gi] = asm_strb_reg[gi] | hit;
        end
    endgenerate
    assign word_last = asm_last_reg | (accept & pack_in_last);

    // A pending word and a freshly completed word are mutually exclusive:
    // while pend is set no element can be accepted.
    assign load    = out_free & (complete | pend_reg);
    assign ld_data = pend_reg ? asm_data_reg : word_data;
    assign ld_strb = pend_reg ? asm_strb_reg : word_strb;
    assign ld_last = pend_reg ? asm_last_reg : word_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg      <= 1'b0;
            lane_reg      <= '0;
            asm_data_reg  <= '0;
            asm_strb_reg  <= '0;
            asm_last_reg  <= 1'b0;
            pend_reg      <= 1'b0;
            last_seen_reg <= 1'b0;
            next_addr_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_strb_reg  <= '0;
            out_addr_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            if (start && !busy_reg) begin
                busy_reg      <= 1'b1;
                next_addr_reg <= base_addr;
            end

            // Output register: load a word, or empty it after a handshake.
            if (load) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ld_data;
                out_strb_reg  <= ld_strb;
                out_last_reg  <= ld_last;
                out_addr_reg  <= next_addr_reg;
                next_addr_reg <= next_addr_reg + ADDR_WIDTH'(1);
            end else if (drain) begin
                out_valid_reg <= 1'b0;
            end

            // Assembly register.
            if (complete && !out_free) begin
                asm_data_reg <= word_data;
                asm_strb_reg <= word_strb;
                asm_last_reg <= word_last;
                pend_reg     <= 1'b1;
            end else if (load) begin
                asm_data_reg <= '0;
                asm_strb_reg <= '0;
                asm_last_reg <= 1'b0;
                pend_reg     <= 1'b0;
            end else if (accept) begin
                asm_data_reg <= word_data;
                asm_strb_reg <= word_strb;
            end

            if (complete) begin
                lane_reg <= '0;
            end else if (accept) begin
                lane_reg <= lane_reg + LW'(1);
            end

            if (accept && pack_in_last) begin
                last_seen_reg <= 1'b1;
            end

            // The burst ends when the word holding the last element is written.
            if (drain && out_last_reg) begin
                busy_reg      <= 1'b0;
                lane_reg      <= '0;
                last_seen_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_strb  = out_strb_reg;
    assign out_addr  = out_addr_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_vpe_out_packer.sv
module tb_vpe_out_packer;
    localparam int OW = 8;
    localparam int L  = 4;
    localparam int AW = 16;
    localparam int W  = OW * L;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          pack_in_valid = 1'b0;
    logic [OW-1:0] pack_in = '0;
    logic          pack_in_last = 1'b0;
    logic          pack_in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [L-1:0]  out_strb;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;

    vpe_out_packer #(.O_WIDTH(OW), .LANES(L), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .pack_in_valid(pack_in_valid), .pack_in(pack_in), .pack_in_last(pack_in_last),
        .pack_in_ready(pack_in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_strb(out_strb), .out_addr(out_addr),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Words that have been formed but not yet written, oldest first.
    logic [W-1:0]  eq_data[$];
    logic [L-1:0]  eq_strb[$];
    logic [AW-1:0] eq_addr[$];
    bit            eq_last[$];
    bit            m_busy;
    int            m_n;
    logic [W-1:0]  m_cur;
    bit            m_last_acc;
    logic [AW-1:0] m_addr;

    // Words actually written by the DUT (for the hand-computed checks).
    logic [W-1:0]  log_data[$];
    logic [L-1:0]  log_strb[$];
    logic [AW-1:0] log_addr[$];
    bit            log_last[$];

    bit acc_s, hs_s, lst_s;
    bit saw_ready_low = 0;

    // At most two words can be outstanding (one being written, one waiting);
    // after the last element nothing more is taken until the burst ends.
    function bit m_ready();
        return m_busy && (eq_data.size() < 2) && !m_last_acc;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eq_data.delete(); eq_strb.delete(); eq_addr.delete(); eq_last.delete();
            m_busy = 0; m_n = 0; m_cur = '0; m_last_acc = 0; m_addr = '0;
        end else begin
            acc_s = pack_in_valid && m_ready();
            hs_s  = (eq_data.size() > 0) && out_ready;
            if (out_valid && out_ready) begin
                log_data.push_back(out_data); log_strb.push_back(out_strb);
                log_addr.push_back(out_addr); log_last.push_back(out_last);
            end
            if (hs_s) begin
                lst_s = eq_last[0];
                void'(eq_data.pop_front()); void'(eq_strb.pop_front());
                void'(eq_addr.pop_front()); void'(eq_last.pop_front());
                if (lst_s) begin
                    m_busy = 0;
                    m_last_acc = 0;
                end
            end
            if (acc_s) begin
                m_cur[m_n*OW +: OW] = pack_in;
                m_n++;
                if (m_n == L || pack_in_last) begin
                    eq_data.push_back(m_cur);
                    eq_strb.push_back(L'((1 << m_n) - 1));
                    eq_addr.push_back(m_addr);
                    eq_last.push_back(pack_in_last);
                    m_addr = m_addr + 1'b1;
                    m_cur = '0;
                    m_n = 0;
                end
                if (pack_in_last) m_last_acc = 1;
            end
            if (start && !m_busy) begin
                m_busy = 1;
                m_addr = base_addr;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs",
                {out_valid, out_data, out_strb, out_addr, out_last, busy, pack_in_ready},
                64'd0);
        end else begin
            if (m_busy && !pack_in_ready) saw_ready_low = 1;
            chk("busy", busy, m_busy);
            chk("pack_in_ready", pack_in_ready, m_ready());
            chk("out_valid", out_valid, eq_data.size() > 0);
            if (out_valid && eq_data.size() > 0) begin
                chk("out_data", out_data, eq_data[0]);
                chk("out_strb", out_strb, eq_strb[0]);
                chk("out_addr", out_addr, eq_addr[0]);
                chk("out_last", out_last, eq_last[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit gap_en = 0;
    logic [OW-1:0] elems[64];

    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 0) ? 1'b1 :
                    (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [OW-1:0] d, input bit last);
        bit r;
        bit ok;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            pack_in_valid = 0;
            @(posedge clk); #1;
        end
        pack_in_valid = 1; pack_in = d; pack_in_last = last;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); r = pack_in_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) send(elems[i], i == n - 1);
        pack_in_valid = 0; pack_in_last = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        start = 1; base_addr = b;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy && !out_valid && eq_data.size() == 0) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_log(input int idx, input logic [W-1:0] d, input logic [L-1:0] s,
                           input logic [AW-1:0] a, input bit lst);
        if (idx >= log_data.size()) begin
            chk("word_missing", log_data.size(), idx + 1);
            return;
        end
        chk("lit_data", log_data[idx], d);
        chk("lit_strb", log_strb[idx], s);
        chk("lit_addr", log_addr[idx], a);
        chk("lit_last", log_last[idx], lst);
    endtask

    int lb;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;

        // 1: two full words, write port always ready
        lb = log_data.size();
        pulse_start(16'h0010);
        for (int i = 0; i < 8; i++) elems[i] = OW'(i + 1);
        burst(8);
        wait_idle();
        chk_log(lb,     32'h04030201, 4'hF, 16'h0010, 0);
        chk_log(lb + 1, 32'h08070605, 4'hF, 16'h0011, 1);
        chk("t1_busy_low", busy, 0);

        // 2: partial last word
        lb = log_data.size();
        pulse_start(16'h0020);
        burst(6);
        wait_idle();
        chk_log(lb + 1, 32'h00000605, 4'h3, 16'h0021, 1);

        // 3: write port stalled while streaming
        lb = log_data.size();
        saw_ready_low = 0;
        ready_mode = 2;
        pulse_start(16'h0050);
        elems[0] = 8'h80; elems[1] = 8'h7F;
        for (int i = 2; i < 12; i++) elems[i] = OW'(i + 1);
        fork
            burst(12);
            begin repeat (10) @(posedge clk); ready_mode = 0; end
        join
        wait_idle();
        chk("t3_ready_dropped", saw_ready_low, 1);
        chk_log(lb,     32'h04037F80, 4'hF, 16'h0050, 0);
        chk_log(lb + 1, 32'h08070605, 4'hF, 16'h0051, 0);
        chk_log(lb + 2, 32'h0C0B0A09, 4'hF, 16'h0052, 1);

        // 4: address wrap
        lb = log_data.size();
        pulse_start(16'hFFFF);
        for (int i = 0; i < 8; i++) elems[i] = OW'(i + 1);
        burst(8);
        wait_idle();
        chk_log(lb,     32'h04030201, 4'hF, 16'hFFFF, 0);
        chk_log(lb + 1, 32'h08070605, 4'hF, 16'h0000, 1);

        // 5: reset in mid-burst
        pulse_start(16'h0060);
        for (int i = 0; i < 3; i++) send(OW'(8'hA0 + i), 0);
        pack_in_valid = 0;
        rst = 0;
        #1;
        chk("t5_reset_busy", busy, 0);
        chk("t5_reset_ready", pack_in_ready, 0);
        chk("t5_reset_valid", out_valid, 0);
        chk("t5_reset_data", out_data, 0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        lb = log_data.size();
        pulse_start(16'h0070);
        for (int i = 0; i < 4; i++) elems[i] = OW'(8'hB1 + i);
        burst(4);
        wait_idle();
        chk("t5_word_count", log_data.size(), lb + 1);
        chk_log(lb, 32'hB4B3B2B1, 4'hF, 16'h0070, 1);

        // 6: start while busy is ignored; then a one-element burst
        lb = log_data.size();
        pulse_start(16'h0030);
        for (int i = 0; i < 4; i++) send(OW'(i + 1), 0);
        pack_in_valid = 0;
        pulse_start(16'h0100);
        for (int i = 0; i < 4; i++) send(OW'(i + 5), i == 3);
        pack_in_valid = 0; pack_in_last = 0;
        wait_idle();
        chk_log(lb,     32'h04030201, 4'hF, 16'h0030, 0);
        chk_log(lb + 1, 32'h08070605, 4'hF, 16'h0031, 1);
        lb = log_data.size();
        pulse_start(16'h0040);
        elems[0] = 8'h7F;
        burst(1);
        wait_idle();
        chk_log(lb, 32'h0000007F, 4'h1, 16'h0040, 1);

        // random bursts with random backpressure and input gaps
        ready_mode = 1;
        gap_en = 1;
        for (int b = 0; b < 30; b++) begin
            int n;
            n = $urandom_range(1, 13);
            for (int i = 0; i < n; i++) elems[i] = OW'($urandom);
            pulse_start(AW'($urandom));
            burst(n);
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        chk("watchdog", 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
